mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 74 +++++++
 tb/tb_mem_port_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter sharing one memory port between instruction fetch and data,
// with a single transaction in flight and a fixed read latency of MEM_LAT cycles.
module mem_port_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MEM_LAT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic          mem_sel,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          if_gnt,
    output logic          dm_gnt,
    output logic          if_rvalid,
    output logic          dm_rvalid,
    output logic [DW-1:0] if_rdata,
    output logic [DW-1:0] dm_rdata,
    output logic          if_stall,
    output logic          dm_stall,
    output logic          busy
);
    typedef enum logic {IDLE, WAIT} state_t;
    state_t     state;
    logic [1:0] cnt;
    logic       owner_q, last_dm;
    logic       grant, win_dm, done;

    // fetch only beats data when both ask and data won last time
    assign win_dm    = dm_req & (~if_req | ~last_dm);
    assign grant     = rst_n & (state == IDLE) & (if_req | dm_req);
    assign done      = (state == WAIT) & (cnt == 2'd0);
    assign if_gnt    = grant & ~win_dm;
    assign dm_gnt    = grant & win_dm;
    assign mem_en    = grant;
    assign mem_we    = dm_gnt & dm_we;
    assign mem_sel   = grant ? win_dm : owner_q;
    assign mem_addr  = mem_sel ? dm_addr : if_addr;
    assign mem_wdata = dm_wdata;
    assign busy      = state == WAIT;
    assign if_rvalid = done & ~owner_q;
    assign dm_rvalid = done & owner_q;
    assign if_rdata  = mem_rdata;
    assign dm_rdata  = mem_rdata;
    assign if_stall  = (if_req & ~if_gnt) | (busy & ~owner_q);
    assign dm_stall  = (dm_req & ~dm_gnt) | (busy & owner_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= 2'd0;
            owner_q <= 1'b0;
            last_dm <= 1'b0;
        end else if (grant) begin
            state   <= WAIT;
            cnt     <= 2'(MEM_LAT - 1);
            owner_q <= win_dm;
            last_dm <= win_dm;
        end else if (done) begin
            state   <= IDLE;
        end else if (cnt != 2'd0) begin
            cnt     <= cnt - 2'd1;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for the memory port arbiter; a time-based transaction
// model predicts grants and responses, a negedge monitor compares them against the DUT.
module tb_mem_port_arbiter;
    localparam int LAT = 2;
    typedef struct {int cyc; logic dm; logic [31:0] addr; logic we; logic [31:0] wdata;} gnt_t;
    typedef struct {int cyc; logic dm; logic rd; logic [31:0] data;} rsp_t;
    typedef struct {int cyc; logic [31:0] data;} mem_t;

    logic clk = 0, rst_n = 0;
    logic if_req = 0, dm_req = 0, dm_we = 0;
    logic [31:0] if_addr = 0, dm_addr = 0, dm_wdata = 0, mem_rdata = 0;
    logic mem_en, mem_we, mem_sel, if_gnt, dm_gnt, if_rvalid, dm_rvalid, if_stall, dm_stall, busy;
    logic [31:0] mem_addr, mem_wdata, if_rdata, dm_rdata;

    logic z_if_req = 0, z_dm_req = 0, z_dm_we = 0;
    logic [31:0] z_if_addr = 0, z_dm_addr = 0, z_dm_wdata = 0, z_mem_rdata = 32'h1234_5678;
    logic s_mem_en [2], s_mem_we [2], s_mem_sel [2], s_if_gnt [2], s_dm_gnt [2];
    logic s_if_rvalid [2], s_dm_rvalid [2], s_if_stall [2], s_dm_stall [2], s_busy [2];
    logic [31:0] s_mem_addr [2], s_mem_wdata [2], s_if_rdata [2], s_dm_rdata [2];

    int checks = 0, errors = 0, cyc = 0, free_at = 0, gnt_cyc = -1;
    logic last_dm = 0, owner = 0, m_if_gnt = 0, m_dm_gnt = 0, mon_en = 0;
    logic e_busy = 0, e_if_stall = 0, e_dm_stall = 0;
    gnt_t gq[$];
    rsp_t rq[$];
    mem_t mq[$];
    gnt_t g;
    rsp_t r;
    mem_t m;

    mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .if_req(if_req), .if_addr(if_addr), .dm_req(dm_req),
        .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .mem_rdata(mem_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_sel(mem_sel), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .if_gnt(if_gnt), .dm_gnt(dm_gnt), .if_rvalid(if_rvalid),
        .dm_rvalid(dm_rvalid), .if_rdata(if_rdata), .dm_rdata(dm_rdata), .if_stall(if_stall),
        .dm_stall(dm_stall), .busy(busy)
    );

    for (genvar i = 0; i < 2; i++) begin : g_sw
        mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(i == 0 ? 1 : 4)) u_sw (
            .clk(clk), .rst_n(rst_n), .if_req(z_if_req), .if_addr(z_if_addr), .dm_req(z_dm_req),
            .dm_we(z_dm_we), .dm_addr(z_dm_addr), .dm_wdata(z_dm_wdata), .mem_rdata(z_mem_rdata),
            .mem_en(s_mem_en[i]), .mem_we(s_mem_we[i]), .mem_sel(s_mem_sel[i]),
            .mem_addr(s_mem_addr[i]), .mem_wdata(s_mem_wdata[i]), .if_gnt(s_if_gnt[i]),
            .dm_gnt(s_dm_gnt[i]), .if_rvalid(s_if_rvalid[i]), .dm_rvalid(s_dm_rvalid[i]),
            .if_rdata(s_if_rdata[i]), .dm_rdata(s_dm_rdata[i]), .if_stall(s_if_stall[i]),
            .dm_stall(s_dm_stall[i]), .busy(s_busy[i])
        );
    end

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // memory contents are a fixed function of the address; 0x100 reads back 0xDEADBEEF
    function automatic logic [31:0] mem_val(input logic [31:0] a);
        return a ^ 32'hDEAD_BFEF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc %0d got %h want %h", name, cyc, act, exp);
        end
    endtask

    task automatic tick();
        mem_t t;
        @(posedge clk);
        #1;
        mem_rdata = $urandom;
        if (mq.size() != 0 && mq[0].cyc == cyc) begin
            t = mq.pop_front();
            mem_rdata = t.data;
        end
    endtask

    // reference model: one transaction at a time, next grant no earlier than grant+LAT+1
    task automatic eval();
        logic w;
        m_if_gnt = 0;
        m_dm_gnt = 0;
        if (rst_n && cyc >= free_at && (if_req || dm_req)) begin
            w = dm_req && !(if_req && last_dm);
            m_dm_gnt = w;
            m_if_gnt = !w;
            gq.push_back('{cyc, w, w ? dm_addr : if_addr, w && dm_we, dm_wdata});
            rq.push_back('{cyc + LAT, w, !(w && dm_we), mem_val(w ? dm_addr : if_addr)});
            free_at = cyc + LAT + 1;
            gnt_cyc = cyc;
            last_dm = w;
            owner = w;
        end
        e_busy = rst_n && cyc > gnt_cyc && cyc < free_at;
        e_if_stall = (if_req && !m_if_gnt) || (e_busy && !owner);
        e_dm_stall = (dm_req && !m_dm_gnt) || (e_busy && owner);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            tick();
            eval();
        end
    endtask

    task automatic hit_reset();
        rst_n = 0;
        free_at = 0;
        gnt_cyc = -1;
        last_dm = 0;
        owner = 0;
        gq.delete();
        rq.delete();
        mq.delete();
        eval();
    endtask

    always @(negedge clk) if (mon_en) begin
        chk("busy", busy, e_busy);
        chk("if_stall", if_stall, e_if_stall);
        chk("dm_stall", dm_stall, e_dm_stall);
        if (mem_en) begin
            m = '{cyc + LAT, mem_val(mem_addr)};
            mq.push_back(m);
        end
        if (if_gnt || dm_gnt || mem_en || (gq.size() != 0 && gq[0].cyc <= cyc)) begin
            if (gq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL grant_unexpected cyc %0d got if_gnt=%0b dm_gnt=%0b want none", cyc, if_gnt, dm_gnt);
            end else begin
                g = gq.pop_front();
                chk("gnt_cyc", cyc, g.cyc);
                chk("if_gnt", if_gnt, !g.dm);
                chk("dm_gnt", dm_gnt, g.dm);
                chk("mem_en", mem_en, 1);
                chk("mem_sel", mem_sel, g.dm);
                chk("mem_addr", mem_addr, g.addr);
                chk("mem_we", mem_we, g.we);
                if (g.dm) chk("mem_wdata", mem_wdata, g.wdata);
            end
        end
        if (if_rvalid || dm_rvalid || (rq.size() != 0 && rq[0].cyc <= cyc)) begin
            if (rq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rvalid_unexpected cyc %0d got if_rvalid=%0b dm_rvalid=%0b want none", cyc, if_rvalid, dm_rvalid);
            end else begin
                r = rq.pop_front();
                chk("rv_cyc", cyc, r.cyc);
                chk("if_rvalid", if_rvalid, !r.dm);
                chk("dm_rvalid", dm_rvalid, r.dm);
                if (r.rd) chk("rdata", r.dm ? dm_rdata : if_rdata, r.data);
            end
        end
    end

    initial begin
        int t0;
        int seen [2];
        if_req = 1;
        dm_req = 1;
        #1;
        chk("rst_if_gnt", if_gnt, 0);
        chk("rst_dm_gnt", dm_gnt, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_sel", mem_sel, 0);
        chk("rst_busy", busy, 0);
        if_req = 0;
        dm_req = 0;
        repeat (2) tick();
        mon_en = 1;
        // single fetch read
        tick();
        rst_n = 1;
        if_req = 1;
        if_addr = 32'h100;
        eval();
        #1;
        chk("c0_if_gnt", if_gnt, 1);
        chk("c0_mem_addr", mem_addr, 32'h100);
        chk("c0_mem_sel", mem_sel, 0);
        tick();
        if_req = 0;
        eval();
        tick();
        eval();
        #1;
        chk("c2_if_rvalid", if_rvalid, 1);
        chk("c2_if_rdata", if_rdata, 32'hDEAD_BEEF);
        tick();
        eval();
        #1;
        chk("c3_idle", busy, 0);
        // single data write
        tick();
        dm_req = 1;
        dm_we = 1;
        dm_addr = 32'h200;
        dm_wdata = 32'h55;
        eval();
        #1;
        chk("w_mem_we", mem_we, 1);
        chk("w_mem_sel", mem_sel, 1);
        chk("w_mem_wdata", mem_wdata, 32'h55);
        tick();
        dm_req = 0;
        eval();
        tick();
        eval();
        #1;
        chk("w_dm_rvalid", dm_rvalid, 1);
        idle(2);
        // both requests held from reset
        tick();
        hit_reset();
        tick();
        rst_n = 1;
        if_req = 1;
        dm_req = 1;
        dm_we = 0;
        if_addr = 32'h300;
        dm_addr = 32'h400;
        for (int i = 0; i < 9; i++) begin
            if (i > 0) tick();
            eval();
            #1;
            if (i == 0) chk("rr_dm_c0", dm_gnt, 1);
            if (i == 3) chk("rr_if_c3", if_gnt, 1);
            if (i == 6) chk("rr_dm_c6", dm_gnt, 1);
        end
        tick();
        if_req = 0;
        dm_req = 0;
        eval();
        idle(3);
        // data request arriving while fetch is outstanding
        tick();
        if_req = 1;
        if_addr = 32'h104;
        eval();
        tick();
        if_req = 0;
        dm_req = 1;
        dm_we = 0;
        dm_addr = 32'h208;
        eval();
        #1;
        chk("wait_dm_stall_c1", dm_stall, 1);
        tick();
        eval();
        #1;
        chk("wait_dm_stall_c2", dm_stall, 1);
        tick();
        eval();
        #1;
        chk("wait_dm_gnt_c3", dm_gnt, 1);
        tick();
        dm_req = 0;
        eval();
        idle(3);
        // reset during an outstanding data read
        tick();
        dm_req = 1;
        dm_we = 0;
        dm_addr = 32'h20C;
        eval();
        tick();
        dm_req = 0;
        eval();
        #2;
        hit_reset();
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_dm_rvalid", dm_rvalid, 0);
        idle(2);
        tick();
        rst_n = 1;
        if_req = 1;
        dm_req = 1;
        if_addr = 32'h108;
        eval();
        #1;
        chk("postrst_dm_gnt", dm_gnt, 1);
        tick();
        dm_req = 0;
        eval();
        idle(2);
        tick();
        if_req = 0;
        eval();
        idle(3);
        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            tick();
            if (!if_req || m_if_gnt) begin
                if_req = $urandom_range(0, 2) != 0;
                if_addr = $urandom;
            end
            if (!dm_req || m_dm_gnt) begin
                dm_req = $urandom_range(0, 2) != 0;
                dm_we = $urandom_range(0, 1);
                dm_addr = $urandom;
                dm_wdata = $urandom;
            end
            eval();
        end
        tick();
        if_req = 0;
        dm_req = 0;
        eval();
        idle(5);
        // latency sweep on the MEM_LAT=1 and MEM_LAT=4 instances
        seen[0] = 0;
        seen[1] = 0;
        tick();
        eval();
        z_if_req = 1;
        z_if_addr = 32'h40;
        #1;
        chk("sw1_gnt", s_if_gnt[0], 1);
        chk("sw4_gnt", s_if_gnt[1], 1);
        for (int n = 1; n <= 8; n++) begin
            tick();
            eval();
            z_if_req = 0;
            #1;
            for (int k = 0; k < 2; k++) if (s_if_rvalid[k] && seen[k] == 0) seen[k] = n;
        end
        chk("sw1_lat", seen[0], 1);
        chk("sw4_lat", seen[1], 4);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
